fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the five-stage MIPS pipeline. It replaces the bare PC/PC+4 path
//  with a prefetch queue between the synchronous instruction RAM and IF/ID.
//  It owns the PC and issues one word fetch per cycle while queue space exists. It buffers responses in a FIFO
//  and hands {instr, pc+4} to decode with a valid/ready handshake. Branch/jump redirects from ID flush the
//  queue and drop any in-flight fetch.
// PARAMETERS
//  XLEN      32          data/address width in bits
//  DEPTH     4           queue entries; power of two, >=2
//  RESET_PC  32'h0       PC loaded on reset (byte address, word aligned)
// PORTS
//  clk             in   1            rising-edge clock
//  rst             in   1            synchronous reset, active high
//  imem_req        out  1            fetch request this cycle
//  imem_addr       out  XLEN         word address (pc >> 2) of the request
//  imem_rdata      in   XLEN         instruction word, valid exactly 1 cycle after imem_req
//  redirect_valid  in   1            ID resolved a taken branch/jump this cycle
//  redirect_pc     in   XLEN         new byte PC (word aligned)
//  out_valid       out  1            queue head holds a valid instruction
//  out_ready       in   1            decode accepts head (low = hazard stall)
//  out_instr       out  XLEN         head instruction word
//  out_pc4         out  XLEN         head PC + 4
//  queue_count     out  $clog2(DEPTH)+1  occupied entries (debug/perf)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, queue empty, in-flight flag clear. Outputs: imem_req=0, out_valid=0, queue_count=0,
//    out_instr=0, out_pc4=0. Reset overrides redirect and handshake in the same cycle.
//  - Issue: imem_req=1 when !rst && !redirect_valid && (count + inflight) < DEPTH. A dequeue in the same cycle
//    frees one slot for this check. On issue, pc <= pc+4 (mod 2^XLEN, wraps silently). The issued PC is
//    registered with the in-flight flag.
//  - Response: the cycle after issue, imem_rdata and the registered PC+4 are written to the tail unless killed.
//    Space is guaranteed by the issue rule, so there is never overflow or drop.
//  - Dequeue: transfer when out_valid && out_ready; head advances next edge. out_* are driven from the head
//    entry (registered storage, combinational read); they are held stable while out_valid && !out_ready.
//  - Latency: queue empty, no redirect -> instruction at pc appears at out_valid 2 cycles after the issue
//    cycle (issue, RAM read, enqueue edge). Throughput: 1 instr/cycle when out_ready stays high.
//  - Simultaneous enqueue+dequeue: count unchanged, both pointers advance. Full with dequeue: enqueue allowed.
//    Empty: no dequeue; a response never bypasses to out_* in the cycle it arrives.
//  - Redirect (redirect_valid=1): next edge pc <= redirect_pc+4 if the target is issued... rule: in the
//    redirect cycle imem_req=0. Next edge pc <= redirect_pc, count/pointers <= 0, in-flight response killed
//    (not enqueued). A same-cycle dequeue still completes on the handshake, but its entry is discarded by the
//    flush. First post-redirect fetch issues the following cycle.
//  - Back-to-back redirects: the last one wins; each cycle's redirect kills all older state.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally; count is a separate register, 0..DEPTH.
//  - Assertions: count never > DEPTH; no enqueue when full; redirect_pc[1:0]==0.
// TESTING
//  1. Reset, out_ready=1 -> imem_addr 0,1,2,3... each cycle; out_pc4 4,8,12... from cycle 3; 1 instr/cycle.
//  2. out_ready=0 from start, DEPTH=4 -> exactly 4 requests, queue_count=4, imem_req stays 0, head frozen at
//     pc4=4. Release out_ready -> 4 drains in 4 cycles, then fetch resumes at addr 4.
//  3. Redirect to 32'h100 while 3 entries queued and one in flight -> queue_count=0 next cycle. In-flight word
//     never appears; next out_pc4=32'h104.
//  4. Redirect on two consecutive cycles (0x40 then 0x80) -> only 0x80 stream delivered, out_pc4=0x84 first.
//  5. Full queue with out_ready=1 continuously -> enqueue+dequeue each cycle, queue_count steady, no lost or
//     duplicated instructions (scoreboard vs RAM contents).
//  6. rst asserted mid-stream with redirect_valid=1 -> next cycle pc=RESET_PC, out_valid=0, count=0; PC wrap
//     test: RESET_PC=32'hFFFF_FFFC -> second fetch addr 0.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch stage with a prefetch queue sitting between a synchronous
// instruction RAM and the IF/ID boundary. The unit owns the PC. It issues at
// most one word fetch per cycle and buffers the returned words in a small
// FIFO. Decode takes each instruction through a valid/ready handshake as the
// pair {instr, pc+4}. A redirect from ID (taken branch or jump) flushes the
// queue and discards any fetch that is still in flight.
//
// Parameters
//   XLEN      data/address width in bits
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  byte PC loaded on reset (word aligned)
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   synchronous reset, active high
//   imem_req        out  fetch request this cycle
//   imem_addr       out  word address (pc >> 2) of the request
//   imem_rdata      in   instruction word, valid exactly 1 cycle after imem_req
//   redirect_valid  in   ID resolved a taken branch/jump this cycle
//   redirect_pc     in   new byte PC (word aligned)
//   out_valid       out  queue head holds a valid instruction
//   out_ready       in   decode accepts the head (low = hazard stall)
//   out_instr       out  head instruction word (0 when the queue is empty)
//   out_pc4         out  head PC + 4 (0 when the queue is empty)
//   queue_count     out  occupied entries (debug/perf)
//
// Handshake: a transfer happens on a rising edge where out_valid && out_ready
// are both high. While out_valid is high and out_ready is low, the head entry
// and therefore out_* stay unchanged. out_valid does not depend on out_ready.
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_pc4,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Architectural state
  logic [XLEN-1:0]  r_pc;
  logic             r_inflight;      // a fetch was issued last cycle
  logic [XLEN-1:0]  r_inflight_pc4;  // PC+4 of that fetch
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  // Queue storage. It has no reset because out_* are gated by out_valid.
  logic [XLEN-1:0]  r_q_instr [DEPTH];
  logic [XLEN-1:0]  r_q_pc4   [DEPTH];

  logic             w_out_valid;
  logic             w_deq;
  logic             w_enq;
  logic             w_issue;
  logic [CNT_W:0]   w_occupancy;
  logic [XLEN-1:0]  w_pc_plus4;

  assign w_out_valid = (r_count != '0);
  assign w_deq       = w_out_valid && out_ready;

  // The response to last cycle's fetch arrives now. A redirect or reset in
  // this same cycle kills it, so it is never written into the queue.
  assign w_enq = r_inflight && !redirect_valid && !rst;

  // Occupancy counts queued entries plus the one response that may be in
  // flight. A dequeue this cycle frees one slot for the issue decision. A
  // dequeue requires r_count >= 1, so the subtraction cannot underflow.
  assign w_occupancy = {1'b0, r_count}
                     + (CNT_W + 1)'(r_inflight)
                     - (CNT_W + 1)'(w_deq);

  // This rule reserves a slot for every fetch before it is issued. The
  // enqueue path therefore never has to drop a word or stall the RAM.
  assign w_issue = !rst && !redirect_valid
                && (w_occupancy < (CNT_W + 1)'(DEPTH));

  assign w_pc_plus4 = r_pc + XLEN'(4);

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc >> 2;

  assign out_valid   = w_out_valid;
  assign out_instr   = w_out_valid ? r_q_instr[r_rd_ptr] : '0;
  assign out_pc4     = w_out_valid ? r_q_pc4[r_rd_ptr]   : '0;
  assign queue_count = r_count;

  // Control state: PC, in-flight tracking, pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_inflight     <= 1'b0;
      r_inflight_pc4 <= '0;
      r_count        <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
    end else if (redirect_valid) begin
      // A redirect discards all older state. A dequeue that completes in
      // this cycle has already handed its entry to decode, and decode drops
      // it, so the flush overrides pointer advance.
      r_pc           <= redirect_pc;
      r_inflight     <= 1'b0;
      r_inflight_pc4 <= '0;
      r_count        <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc           <= w_pc_plus4;
        r_inflight_pc4 <= w_pc_plus4;
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  // Data path: write the returned word and its PC+4 at the tail.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_pc4[r_wr_ptr]   <= r_inflight_pc4;
    end
  end

  // Structural invariants
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    r_count <= CNT_W'(DEPTH));

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_enq && !w_deq && (r_count == CNT_W'(DEPTH))));

  a_redirect_aligned : assert property (@(posedge clk) disable iff (rst)
    redirect_valid |-> (redirect_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
//
// This bench drives fetch_queue_unit with a linear sequence of directed
// steps. The expected values are computed by hand. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers the PC wrap case. Each instance has a
// synchronous RAM model that returns a word derived from the address one
// cycle after it is presented.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [2:0]  queue_count;

  logic        wrap_imem_req;
  logic [31:0] wrap_imem_addr;
  logic [31:0] wrap_imem_rdata;
  logic        wrap_out_valid;
  logic [31:0] wrap_out_instr;
  logic [31:0] wrap_out_pc4;
  logic [2:0]  wrap_queue_count;
  logic        wrap_out_ready = 1'b1;
  logic        wrap_redirect_valid = 1'b0;
  logic [31:0] wrap_redirect_pc = 32'h0;

  int checks = 0;
  int errors = 0;

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc4        (out_pc4),
    .queue_count    (queue_count)
  );

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (wrap_imem_req),
    .imem_addr      (wrap_imem_addr),
    .imem_rdata     (wrap_imem_rdata),
    .redirect_valid (wrap_redirect_valid),
    .redirect_pc    (wrap_redirect_pc),
    .out_valid      (wrap_out_valid),
    .out_ready      (wrap_out_ready),
    .out_instr      (wrap_out_instr),
    .out_pc4        (wrap_out_pc4),
    .queue_count    (wrap_queue_count)
  );

  // Instruction RAM contents: a fixed function of the word address.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  always @(posedge clk) begin
    imem_rdata      <= ram_word(imem_addr);
    wrap_imem_rdata <= ram_word(wrap_imem_addr);
  end

  // ---------------- driver / check helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] exp_pc4;
    int          delivered;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    tick();
    tick();
    #1;
    check("rst_req",   {31'b0, imem_req},    32'h0);
    check("rst_valid", {31'b0, out_valid},   32'h0);
    check("rst_count", {29'b0, queue_count}, 32'h0);
    check("rst_instr", out_instr,            32'h0);
    check("rst_pc4",   out_pc4,              32'h0);

    // 1: streaming with out_ready high. The wrap instance runs alongside.
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t1_req",  {31'b0, imem_req}, 32'h1);
      check("t1_addr", imem_addr, 32'(k));
      if (k >= 2) begin
        check("t1_valid", {31'b0, out_valid}, 32'h1);
        check("t1_pc4",   out_pc4, 32'(4 * (k - 1)));
        check("t1_instr", out_instr, ram_word(32'(k - 2)));
        check("t1_count", {29'b0, queue_count}, 32'h1);
      end else begin
        check("t1_empty", {31'b0, out_valid}, 32'h0);
      end
      if (k == 0) begin
        check("wrap_addr0", wrap_imem_addr, 32'h3FFF_FFFF);
        check("wrap_count0", {29'b0, wrap_queue_count}, 32'h0);
      end
      if (k == 1) check("wrap_addr1", wrap_imem_addr, 32'h0);
      if (k == 2) begin
        check("wrap_valid", {31'b0, wrap_out_valid}, 32'h1);
        check("wrap_pc4",   wrap_out_pc4, 32'h0);
        check("wrap_instr", wrap_out_instr, ram_word(32'h3FFF_FFFF));
        check("wrap_req",   {31'b0, wrap_imem_req}, 32'h1);
      end
      tick();
    end

    // 2 + 5: stall from reset fills the queue. Release it, then full-rate
    // streaming keeps the occupancy steady.
    rst       = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t2_req", {31'b0, imem_req}, (k < 4) ? 32'h1 : 32'h0);
      if (k < 4) check("t2_addr", imem_addr, 32'(k));
      if (k == 7) begin
        check("t2_full",  {29'b0, queue_count}, 32'h4);
        check("t2_valid", {31'b0, out_valid}, 32'h1);
        check("t2_hold",  out_pc4, 32'h4);
        check("t2_hinst", out_instr, ram_word(32'h0));
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 8; k < 28; k++) begin
      #1;
      check("t2_req_r",  {31'b0, imem_req}, 32'h1);
      check("t2_addr_r", imem_addr, 32'(k - 4));
      check("t5_pc4",    out_pc4, 32'(4 * (k - 7)));
      check("t5_instr",  out_instr, ram_word(32'(k - 8)));
      if (k >= 9) check("t5_count", {29'b0, queue_count}, 32'h3);
      tick();
    end

    // 3: redirect while 3 entries are queued and one fetch is in flight.
    rst       = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #1;
    check("t3_pre_count", {29'b0, queue_count}, 32'h3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("t3_req_redir", {31'b0, imem_req}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #1;
    check("t3_count",  {29'b0, queue_count}, 32'h0);
    check("t3_valid0", {31'b0, out_valid}, 32'h0);
    check("t3_addr0",  imem_addr, 32'h40);
    check("t3_req0",   {31'b0, imem_req}, 32'h1);
    tick();
    #1;
    check("t3_valid1", {31'b0, out_valid}, 32'h0);
    check("t3_addr1",  imem_addr, 32'h41);
    tick();
    #1;
    check("t3_valid2", {31'b0, out_valid}, 32'h1);
    check("t3_pc4",    out_pc4, 32'h104);
    check("t3_instr",  out_instr, ram_word(32'h40));
    tick();
    #1;
    check("t3_pc4b", out_pc4, 32'h108);

    // 4: back-to-back redirects; only the last target counts.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check("t4_req_a", {31'b0, imem_req}, 32'h0);
    tick();
    redirect_pc = 32'h80;
    #1;
    check("t4_req_b",   {31'b0, imem_req}, 32'h0);
    check("t4_count_b", {29'b0, queue_count}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_addr0",  imem_addr, 32'h20);
    check("t4_valid0", {31'b0, out_valid}, 32'h0);
    tick();
    #1;
    check("t4_valid1", {31'b0, out_valid}, 32'h0);
    check("t4_addr1",  imem_addr, 32'h21);
    tick();
    #1;
    check("t4_valid2", {31'b0, out_valid}, 32'h1);
    check("t4_pc4",    out_pc4, 32'h84);
    check("t4_instr",  out_instr, ram_word(32'h20));
    tick();
    #1;
    check("t4_pc4b", out_pc4, 32'h88);

    // Random out_ready: every accepted word must follow the sequential
    // stream with no loss or duplication.
    exp_pc4   = 32'h88;
    delivered = 0;
    for (int k = 0; k < 60; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        check("sb_pc4",   out_pc4, exp_pc4);
        check("sb_instr", out_instr, ram_word((exp_pc4 - 32'h4) >> 2));
        exp_pc4 = exp_pc4 + 32'h4;
        delivered++;
      end
      check("sb_count_le", {31'b0, queue_count <= 3'd4}, 32'h1);
      tick();
    end
    check("sb_progress", {31'b0, delivered >= 10}, 32'h1);

    // 6: reset mid-stream together with a redirect; reset wins.
    out_ready      = 1'b1;
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    check("t6_req_rst", {31'b0, imem_req}, 32'h0);
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("t6_count", {29'b0, queue_count}, 32'h0);
    check("t6_valid", {31'b0, out_valid}, 32'h0);
    check("t6_pc4_0", out_pc4, 32'h0);
    check("t6_req",   {31'b0, imem_req}, 32'h1);
    check("t6_addr",  imem_addr, 32'h0);
    tick();
    tick();
    #1;
    check("t6_valid2", {31'b0, out_valid}, 32'h1);
    check("t6_pc4",    out_pc4, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
